// File: rtl/dbg_run_control.sv
// Debug run-control engine: halt / multi-cycle step / resume across CHANNELS
// gated clock domains, with an enabled-cycle counter, a cycle breakpoint and
// a halt-cause report. All outputs are registered clock enables and status.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_RUN  | free running; halt_req or breakpoint hit stops the core
//   ST_HALT | controlled channels gated; waiting for step_req / resume_req
//   ST_STEP | controlled channels enabled while the remaining count runs down
module dbg_run_control #(
   parameter int CHANNELS = 1,
   parameter int STEP_W   = 8,
   parameter int CYC_W    = 32
) (
   input  logic                sys_clk,
   input  logic                dbg_rst,
   input  logic                halt_req,
   input  logic                step_req,
   input  logic                resume_req,
   input  logic [STEP_W-1:0]   step_count,
   input  logic [CHANNELS-1:0] chan_mask,
   input  logic                bp_en,
   input  logic [CYC_W-1:0]    bp_cycle,
   input  logic                cyc_clr,
   output logic [CHANNELS-1:0] clk_en,
   output logic                halted,
   output logic [1:0]          halt_cause,
   output logic                step_done,
   output logic [CYC_W-1:0]    cyc_count
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_RUN  = 2'b00;
   localparam logic [1:0] CAUSE_REQ  = 2'b01;
   localparam logic [1:0] CAUSE_STEP = 2'b10;
   localparam logic [1:0] CAUSE_BP   = 2'b11;

   state_t              state, state_nxt;
   logic [CHANNELS-1:0] mask, mask_nxt;
   logic [STEP_W-1:0]   remaining, remaining_nxt;
   logic [1:0]          cause_nxt;
   logic                done_nxt;
   logic [CYC_W-1:0]    cyc_nxt;
   logic [CHANNELS-1:0] clk_en_nxt;
   logic                bp_hit;

   // Next-state, counters and registered-output precompute.
   always_comb begin
      state_nxt     = state;
      mask_nxt      = mask;
      remaining_nxt = remaining;
      cause_nxt     = halt_cause;
      done_nxt      = 1'b0;

      // The counter still increments when the hit fires, so it lands exactly on
      // bp_cycle; a clearing edge is not an incrementing edge and cannot hit.
      bp_hit = bp_en && (bp_cycle != '0) && !cyc_clr &&
               (cyc_count == (bp_cycle - CYC_W'(1)));

      if (cyc_clr)
         cyc_nxt = '0;
      else if (state != ST_HALT)
         cyc_nxt = cyc_count + CYC_W'(1);
      else
         cyc_nxt = cyc_count;

      case (state)
         ST_RUN: begin
            if (halt_req) begin
               state_nxt = ST_HALT;
               mask_nxt  = chan_mask;
               cause_nxt = CAUSE_REQ;
            end else if (bp_hit) begin
               state_nxt = ST_HALT;
               cause_nxt = CAUSE_BP;
            end
         end
         ST_HALT: begin
            if (step_req && (step_count != '0)) begin
               state_nxt     = ST_STEP;
               remaining_nxt = step_count;
               cause_nxt     = CAUSE_RUN;
            end else if (resume_req) begin
               state_nxt = ST_RUN;
               cause_nxt = CAUSE_RUN;
            end
         end
         ST_STEP: begin
            if (halt_req) begin
               state_nxt     = ST_HALT;
               remaining_nxt = '0;
               cause_nxt     = CAUSE_REQ;
            end else begin
               remaining_nxt = remaining - STEP_W'(1);
               if (remaining == STEP_W'(1)) begin
                  state_nxt = ST_HALT;
                  cause_nxt = CAUSE_STEP;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase

      // Enables are registered from the next state so gating tracks the transition edge.
      clk_en_nxt = ~mask_nxt | {CHANNELS{state_nxt != ST_HALT}};
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!dbg_rst) begin
         state      <= ST_RUN;
         mask       <= '1;
         remaining  <= '0;
         clk_en     <= '1;
         halted     <= 1'b0;
         halt_cause <= CAUSE_RUN;
         step_done  <= 1'b0;
         cyc_count  <= '0;
      end else begin
         state      <= state_nxt;
         mask       <= mask_nxt;
         remaining  <= remaining_nxt;
         clk_en     <= clk_en_nxt;
         halted     <= (state_nxt == ST_HALT);
         halt_cause <= cause_nxt;
         step_done  <= done_nxt;
         cyc_count  <= cyc_nxt;
      end
   end

endmodule

// File: tb/tb_dbg_run_control.sv
// Bench for dbg_run_control: expected output values are queued with the edge
// after which they must hold, and a negedge monitor compares them as they fall due.
module tb_dbg_run_control;

   localparam int CHANNELS = 2;
   localparam int STEP_W   = 8;
   localparam int CYC_W    = 8;

   localparam int F_CLK   = 0;
   localparam int F_HALT  = 1;
   localparam int F_CAUSE = 2;
   localparam int F_DONE  = 3;
   localparam int F_CYC   = 4;

   logic                sys_clk = 1'b0;
   logic                dbg_rst = 1'b0;
   logic                halt_req = 1'b0;
   logic                step_req = 1'b0;
   logic                resume_req = 1'b0;
   logic [STEP_W-1:0]   step_count = '0;
   logic [CHANNELS-1:0] chan_mask = '0;
   logic                bp_en = 1'b0;
   logic [CYC_W-1:0]    bp_cycle = '0;
   logic                cyc_clr = 1'b0;
   logic [CHANNELS-1:0] clk_en;
   logic                halted;
   logic [1:0]          halt_cause;
   logic                step_done;
   logic [CYC_W-1:0]    cyc_count;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   int          due_q[$];
   string       tag_q[$];
   int          fld_q[$];
   logic [31:0] exp_q[$];

   dbg_run_control #(
      .CHANNELS (CHANNELS),
      .STEP_W   (STEP_W),
      .CYC_W    (CYC_W)
   ) dut (
      .sys_clk    (sys_clk),
      .dbg_rst    (dbg_rst),
      .halt_req   (halt_req),
      .step_req   (step_req),
      .resume_req (resume_req),
      .step_count (step_count),
      .chan_mask  (chan_mask),
      .bp_en      (bp_en),
      .bp_cycle   (bp_cycle),
      .cyc_clr    (cyc_clr),
      .clk_en     (clk_en),
      .halted     (halted),
      .halt_cause (halt_cause),
      .step_done  (step_done),
      .cyc_count  (cyc_count)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) edge_n <= edge_n + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   function automatic logic [31:0] obs_fld(input int f);
      case (f)
         F_CLK:   obs_fld = {30'b0, clk_en};
         F_HALT:  obs_fld = {31'b0, halted};
         F_CAUSE: obs_fld = {30'b0, halt_cause};
         F_DONE:  obs_fld = {31'b0, step_done};
         default: obs_fld = {24'b0, cyc_count};
      endcase
   endfunction

   task automatic exp_at(input int due, input string tag, input int fld, input logic [31:0] v);
      due_q.push_back(due);
      tag_q.push_back(tag);
      fld_q.push_back(fld);
      exp_q.push_back(v);
   endtask

   task automatic exp_all(input int due, input string tag, input logic [31:0] ce,
                          input logic [31:0] h, input logic [31:0] c,
                          input logic [31:0] d, input logic [31:0] cy);
      exp_at(due, {tag, "_clk"},   F_CLK,   ce);
      exp_at(due, {tag, "_halt"},  F_HALT,  h);
      exp_at(due, {tag, "_cause"}, F_CAUSE, c);
      exp_at(due, {tag, "_done"},  F_DONE,  d);
      exp_at(due, {tag, "_cyc"},   F_CYC,   cy);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Compare every queued expectation that falls due after the current edge.
   always @(negedge sys_clk) begin
      for (int i = due_q.size() - 1; i >= 0; i--) begin
         if (due_q[i] == edge_n) begin
            check_val(tag_q[i], obs_fld(fld_q[i]), exp_q[i]);
            due_q.delete(i);
            tag_q.delete(i);
            fld_q.delete(i);
            exp_q.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, z, c, r, h, x;

      // reset
      tick(2);
      exp_all(edge_n, "rst", 3, 0, 0, 0, 0);
      dbg_rst = 1'b1;

      // step_req ignored while running
      step_req = 1'b1; step_count = 8'd3;
      tick(1);
      step_req = 1'b0;
      exp_all(edge_n, "run_ign", 3, 0, 0, 0, 1);
      tick(2);

      // halt with chan_mask = 01
      halt_req = 1'b1; chan_mask = 2'b01;
      tick(1);
      halt_req = 1'b0;
      exp_all(edge_n, "halt", 2'b10, 1, 1, 0, 4);
      exp_at(edge_n + 3, "halt_frz", F_CYC, 4);
      tick(4);

      // step 5
      step_req = 1'b1; step_count = 8'd5;
      tick(1);
      step_req = 1'b0;
      s = edge_n;
      for (int i = 0; i < 5; i++) begin
         exp_at(s + i, "step_en", F_CLK, 3);
         exp_at(s + i, "step_nodone", F_DONE, 0);
      end
      exp_all(s + 5, "step_end", 2'b10, 1, 2, 1, 9);
      exp_at(s + 6, "step_pulse", F_DONE, 0);
      tick(7);

      // step_count = 0 ignored
      step_req = 1'b1; step_count = 8'd0;
      tick(1);
      step_req = 1'b0;
      exp_all(edge_n, "step0", 2'b10, 1, 2, 0, 9);
      tick(2);

      // step_req wins over resume_req
      step_req = 1'b1; resume_req = 1'b1; step_count = 8'd2;
      tick(1);
      step_req = 1'b0; resume_req = 1'b0;
      z = edge_n;
      exp_at(z, "sr_halt", F_HALT, 0);
      exp_at(z, "sr_clk", F_CLK, 3);
      exp_all(z + 2, "sr_end", 2'b10, 1, 2, 1, 11);
      tick(4);

      // resume
      resume_req = 1'b1;
      tick(1);
      resume_req = 1'b0;
      exp_all(edge_n, "resume", 3, 0, 0, 0, 11);

      // breakpoint at 100 after a clear
      bp_en = 1'b1; bp_cycle = 8'd100; cyc_clr = 1'b1;
      tick(1);
      cyc_clr = 1'b0;
      c = edge_n;
      exp_at(c, "clr", F_CYC, 0);
      exp_at(c + 99, "bp_pre_halt", F_HALT, 0);
      exp_at(c + 99, "bp_pre_cyc", F_CYC, 99);
      exp_all(c + 100, "bp_hit", 2'b10, 1, 3, 0, 100);
      exp_at(c + 102, "bp_frz", F_CYC, 100);
      tick(103);

      // bp_cycle = 0 never halts, counter wraps through all-ones
      bp_cycle = 8'd0; resume_req = 1'b1;
      tick(1);
      resume_req = 1'b0;
      r = edge_n;
      exp_at(r + 155, "wrap_max", F_CYC, 255);
      exp_at(r + 156, "wrap0", F_CYC, 0);
      exp_at(r + 156, "bp0_halt", F_HALT, 0);
      exp_at(r + 156, "bp0_clk", F_CLK, 3);
      tick(157);

      // halt_req coincident with a breakpoint hit
      bp_cycle = 8'd10; cyc_clr = 1'b1;
      tick(1);
      cyc_clr = 1'b0;
      tick(9);
      exp_at(edge_n, "sim_pre", F_HALT, 0);
      halt_req = 1'b1; chan_mask = 2'b10;
      tick(1);
      halt_req = 1'b0;
      h = edge_n;
      exp_all(h, "sim_hit", 2'b01, 1, 1, 0, 10);
      tick(3);

      // abort a 200-cycle step after 50 cycles
      bp_en = 1'b0;
      step_req = 1'b1; step_count = 8'd200;
      tick(1);
      step_req = 1'b0;
      tick(49);
      chan_mask = 2'b11; halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      exp_all(edge_n, "abort", 2'b01, 1, 1, 0, 60);
      exp_at(edge_n + 1, "abort_nd", F_DONE, 0);
      tick(3);

      // reset in the middle of a step
      step_req = 1'b1; step_count = 8'd50;
      tick(1);
      step_req = 1'b0;
      tick(10);
      dbg_rst = 1'b0;
      tick(1);
      dbg_rst = 1'b1;
      x = edge_n;
      exp_all(x, "rst_step", 3, 0, 0, 0, 0);
      exp_at(x + 3, "rst_run_cyc", F_CYC, 3);
      exp_at(x + 3, "rst_run_halt", F_HALT, 0);
      exp_at(x + 60, "rst_nodone", F_DONE, 0);
      tick(62);

      check_val("sb_drain", due_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
